// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_tracker
// Description : Drains scan-code bytes from ps2_keyboard through the
//               ready/nextdata_n handshake, decodes the E0 (extended) and
//               F0 (break) prefixes into make/break key events, tracks the
//               held key, filters typematic repeats, counts presses and
//               buffers events in a first-word-fall-through FIFO with a
//               valid/ready consumer interface.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker #(
  parameter int FIFO_DEPTH    = 8,     // power of two, >= 2
  parameter int CNT_W         = 8,
  parameter bit REPEAT_FILTER = 1'b1
) (
  input  logic                          clk,
  input  logic                          resetn,
  // ps2_keyboard side
  input  logic [7:0]                    kb_data,
  input  logic                          kb_ready,
  output logic                          kb_nextdata_n,
  // event stream
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  // key status
  output logic                          key_down,
  output logic [7:0]                    held_code,
  output logic                          held_ext,
  output logic [CNT_W-1:0]              press_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ev_overflow,
  input  logic                          clr_ovf
);

  localparam int c_AW = $clog2(FIFO_DEPTH);

  // Prefix-decoder states
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_EXT    = 2'd1;
  localparam logic [1:0] c_ST_BRK    = 2'd2;
  localparam logic [1:0] c_ST_EXTBRK = 2'd3;

  // Special scan-code bytes
  localparam logic [7:0] c_PFX_EXT  = 8'hE0;
  localparam logic [7:0] c_PFX_BRK  = 8'hF0;
  localparam logic [7:0] c_BYTE_NUL = 8'h00;
  localparam logic [7:0] c_BYTE_ERR = 8'hFF;

  localparam logic [c_AW:0]    c_LVL_ZERO = '0;
  localparam logic [c_AW:0]    c_LVL_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW:0]    c_LVL_FULL = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [c_AW-1:0]  c_PTR_ONE  = c_AW'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic              r_guard;
  logic [1:0]        r_state;
  logic              r_key_down;
  logic [7:0]        r_held_code;
  logic              r_held_ext;
  logic [CNT_W-1:0]  r_press_count;
  logic              r_overflow;
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_level;
  // Entry layout: {ext, break, code}
  logic [9:0]        r_mem [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic              w_accept;
  logic [1:0]        w_state_nxt;
  logic              w_ev_make;
  logic              w_ev_brk;
  logic              w_ev_ext;
  logic              w_held_match;
  logic              w_repeat;
  logic              w_make_emit;
  logic              w_push_req;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [c_AW:0]     w_level_nxt;

  // A byte is taken whenever one is offered and the previous cycle was not an
  // accept; the guard cycle gives ps2_keyboard time to advance its head.
  assign w_accept      = kb_ready & ~r_guard;
  assign kb_nextdata_n = ~w_accept;

  // Classify the accepted byte against the current prefix state
  always_comb begin
    w_state_nxt = r_state;
    w_ev_make   = 1'b0;
    w_ev_brk    = 1'b0;
    w_ev_ext    = 1'b0;
    if (w_accept) begin
      if ((kb_data == c_BYTE_NUL) || (kb_data == c_BYTE_ERR)) begin
        // Keyboard error / buffer-overrun bytes abandon any pending prefix
        w_state_nxt = c_ST_IDLE;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if (kb_data == c_PFX_EXT) begin
              w_state_nxt = c_ST_EXT;
            end else if (kb_data == c_PFX_BRK) begin
              w_state_nxt = c_ST_BRK;
            end else begin
              w_ev_make   = 1'b1;
              w_state_nxt = c_ST_IDLE;
            end
          end
          c_ST_EXT: begin
            if (kb_data == c_PFX_BRK) begin
              w_state_nxt = c_ST_EXTBRK;
            end else if (kb_data == c_PFX_EXT) begin
              w_state_nxt = c_ST_EXT;
            end else begin
              w_ev_make   = 1'b1;
              w_ev_ext    = 1'b1;
              w_state_nxt = c_ST_IDLE;
            end
          end
          c_ST_BRK: begin
            if (kb_data == c_PFX_BRK) begin
              w_state_nxt = c_ST_BRK;
            end else if (kb_data == c_PFX_EXT) begin
              w_state_nxt = c_ST_EXTBRK;
            end else begin
              w_ev_brk    = 1'b1;
              w_state_nxt = c_ST_IDLE;
            end
          end
          c_ST_EXTBRK: begin
            if ((kb_data == c_PFX_EXT) || (kb_data == c_PFX_BRK)) begin
              w_state_nxt = c_ST_EXTBRK;
            end else begin
              w_ev_brk    = 1'b1;
              w_ev_ext    = 1'b1;
              w_state_nxt = c_ST_IDLE;
            end
          end
          default: begin
            w_state_nxt = c_ST_IDLE;
          end
        endcase
      end
    end
  end

  // The decoded key matches the currently tracked held key
  assign w_held_match = (kb_data == r_held_code) && (w_ev_ext == r_held_ext);

  // Typematic repeats of the held key are optionally squashed
  generate
    if (REPEAT_FILTER) begin : g_repeat_filter
      assign w_repeat = r_key_down & w_held_match;
    end else begin : g_repeat_pass
      assign w_repeat = 1'b0;
    end
  endgenerate

  assign w_make_emit = w_ev_make & ~w_repeat;
  assign w_push_req  = w_make_emit | w_ev_brk;

  // FIFO control: a pop frees a slot in the same cycle, so a full FIFO can
  // still accept a push alongside a pop.
  assign w_empty = (r_level == c_LVL_ZERO);
  assign w_full  = (r_level == c_LVL_FULL);
  assign w_pop   = ~w_empty & ev_ready;
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;

  // Next FIFO occupancy
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + c_LVL_ONE;
      2'b01:   w_level_nxt = r_level - c_LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Accept guard and prefix-decoder state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_guard <= 1'b0;
      r_state <= c_ST_IDLE;
    end else begin
      r_guard <= w_accept;
      r_state <= w_state_nxt;
    end
  end

  // Held-key tracking and press counter; updated even when the event is dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_key_down    <= 1'b0;
      r_held_code   <= 8'h00;
      r_held_ext    <= 1'b0;
      r_press_count <= '0;
    end else if (w_make_emit) begin
      r_key_down    <= 1'b1;
      r_held_code   <= kb_data;
      r_held_ext    <= w_ev_ext;
      r_press_count <= r_press_count + c_CNT_ONE;
    end else if (w_ev_brk && w_held_match) begin
      // Releasing the held key keeps its identity visible on held_code/ext
      r_key_down    <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_level <= w_level_nxt;
    end
  end

  // FIFO storage; contents are only observed while the level is non-zero
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_ev_ext, w_ev_brk, kb_data};
    end
  end

  // Sticky overflow flag; a drop in the clearing cycle keeps it set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ev_valid    = ~w_empty;
  assign ev_ext      = r_mem[r_rd_ptr][9];
  assign ev_break    = r_mem[r_rd_ptr][8];
  assign ev_code     = r_mem[r_rd_ptr][7:0];
  assign key_down    = r_key_down;
  assign held_code   = r_held_code;
  assign held_ext    = r_held_ext;
  assign press_count = r_press_count;
  assign fifo_level  = r_level;
  assign ev_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_tracker
// Description : Scoreboard bench for ps2_key_tracker. Two instances run in
//               lockstep on the same byte stream, one with the repeat filter
//               enabled and one without. A prefix-flag reference model pushes
//               expected events into per-instance queues; a negedge monitor
//               compares the FIFO head and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  logic clk = 1'b0;
  logic resetn;
  logic [7:0] kb_data;
  logic kb_ready;
  logic ev_ready;
  logic clr_ovf;

  logic [1:0]    kb_nextdata_n, ev_valid, ev_ext, ev_break, key_down, held_ext, ev_overflow;
  logic [7:0]    ev_code [2];
  logic [7:0]    held_code [2];
  logic [CW-1:0] press_count [2];
  logic [LW-1:0] fifo_level [2];

  ps2_key_tracker #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .REPEAT_FILTER(1'b1)) u_dut_f (
    .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_nextdata_n(kb_nextdata_n[0]), .ev_valid(ev_valid[0]), .ev_ready(ev_ready),
    .ev_code(ev_code[0]), .ev_ext(ev_ext[0]), .ev_break(ev_break[0]),
    .key_down(key_down[0]), .held_code(held_code[0]), .held_ext(held_ext[0]),
    .press_count(press_count[0]), .fifo_level(fifo_level[0]),
    .ev_overflow(ev_overflow[0]), .clr_ovf(clr_ovf)
  );

  ps2_key_tracker #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .REPEAT_FILTER(1'b0)) u_dut_n (
    .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_nextdata_n(kb_nextdata_n[1]), .ev_valid(ev_valid[1]), .ev_ready(ev_ready),
    .ev_code(ev_code[1]), .ev_ext(ev_ext[1]), .ev_break(ev_break[1]),
    .key_down(key_down[1]), .held_code(held_code[1]), .held_ext(held_ext[1]),
    .press_count(press_count[1]), .fifo_level(fifo_level[1]),
    .ev_overflow(ev_overflow[1]), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, k, $time, act, exp);
  endtask

  // ------------------------------------------------------- reference model
  byte unsigned kbq[$];          // bytes waiting in the emulated ps2_keyboard
  ev_t q0[$], q1[$];             // expected events per instance
  bit  pre_ext, pre_brk;         // pending prefixes seen since the last key
  bit  m_guard;                  // previous cycle popped a byte
  int  m_level [2];
  bit  m_ovf [2], m_down [2], m_hext [2];
  int  m_hcode [2], m_cnt [2];

  function automatic void qpush(input int k, input ev_t e);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_ext = 0; pre_brk = 0; m_guard = 0;
      q0.delete(); q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_level[k] = 0; m_ovf[k] = 0; m_down[k] = 0; m_hext[k] = 0;
        m_hcode[k] = 0; m_cnt[k] = 0;
      end
    end else begin
      bit   acc, have_ev;
      ev_t  e;
      int   b;
      acc = kb_ready && !m_guard;
      have_ev = 0;
      e = '0;
      if (acc) begin
        b = int'(kb_data);
        if (kbq.size() != 0) void'(kbq.pop_front());
        if (b == 'h00 || b == 'hFF) begin
          pre_ext = 0; pre_brk = 0;
        end else if (b == 'hE0) begin
          pre_ext = 1;
        end else if (b == 'hF0) begin
          pre_brk = 1;
        end else begin
          have_ev = 1;
          e.ext = pre_ext; e.brk = pre_brk; e.code = b[7:0];
          pre_ext = 0; pre_brk = 0;
        end
      end
      m_guard = acc;
      for (int k = 0; k < 2; k++) begin
        bit pop, push, drop, same;
        pop  = (m_level[k] > 0) && ev_ready;
        push = 0;
        same = (int'(e.code) == m_hcode[k]) && (e.ext == m_hext[k]);
        if (have_ev) begin
          if (!e.brk) begin
            if (!(k == 0 && m_down[k] && same)) begin
              push = 1;
              m_cnt[k] = (m_cnt[k] + 1) % (1 << CW);
              m_hcode[k] = int'(e.code); m_hext[k] = e.ext; m_down[k] = 1;
            end
          end else begin
            push = 1;
            if (same) m_down[k] = 0;
          end
        end
        drop = push && (m_level[k] == DEPTH) && !pop;
        if (push && !drop) qpush(k, e);
        m_level[k] = m_level[k] + ((push && !drop) ? 1 : 0) - (pop ? 1 : 0);
        if (drop) m_ovf[k] = 1;
        else if (clr_ovf) m_ovf[k] = 0;
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  int ev_seen [2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ev_t exp_e;
      check("kb_nextdata_n", k, kb_nextdata_n[k], !(kb_ready && !m_guard));
      check("ev_valid", k, ev_valid[k], m_level[k] > 0);
      check("fifo_level", k, fifo_level[k], m_level[k]);
      check("key_down", k, key_down[k], m_down[k]);
      check("held_code", k, held_code[k], m_hcode[k]);
      check("held_ext", k, held_ext[k], m_hext[k]);
      check("press_count", k, press_count[k], m_cnt[k]);
      check("ev_overflow", k, ev_overflow[k], m_ovf[k]);
      if (m_level[k] > 0) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          check("scoreboard_nonempty", k, 0, 1);
        end else begin
          exp_e = (k == 0) ? q0[0] : q1[0];
          check("ev_code", k, ev_code[k], exp_e.code);
          check("ev_ext", k, ev_ext[k], exp_e.ext);
          check("ev_break", k, ev_break[k], exp_e.brk);
          if (ev_ready) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
        end
      end
      if (ev_valid[k] && ev_ready) ev_seen[k]++;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic refresh_kb();
    kb_ready = (kbq.size() != 0);
    kb_data  = (kbq.size() != 0) ? kbq[0] : 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    refresh_kb();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    kbq.delete();
    refresh_kb();
    resetn = 1'b0;
    ticks(3);
    resetn = 1'b1;
    tick();
  endtask

  // Feed a byte sequence and wait (bounded) until all of it is consumed
  task automatic send(input byte unsigned bytes[$]);
    int budget;
    foreach (bytes[i]) kbq.push_back(bytes[i]);
    refresh_kb();
    budget = 0;
    while (kbq.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    if (kbq.size() != 0) check("kb_drain_timeout", 0, kbq.size(), 0);
    ticks(2);
  endtask

  function automatic byte unsigned pick_byte();
    byte unsigned pool[10] = '{8'hE0, 8'hF0, 8'h00, 8'hFF, 8'h1C,
                               8'h15, 8'h75, 8'h23, 8'h1C, 8'h15};
    return pool[$urandom_range(0, 9)];
  endfunction

  initial begin
    int base0, base1, lows, mode;
    resetn = 1'b1; kb_ready = 1'b0; kb_data = 8'h00; ev_ready = 1'b1; clr_ovf = 1'b0;
    #1;
    do_reset();

    // Press and release a plain key
    base0 = ev_seen[0];
    send('{8'h1C, 8'hF0, 8'h1C});
    check("t1_events", 0, ev_seen[0] - base0, 2);
    check("t1_press_count", 0, press_count[0], 1);
    check("t1_key_down", 0, key_down[0], 0);

    // Extended key press then release
    do_reset();
    send('{8'hE0, 8'h75});
    check("t2_key_down_pressed", 0, key_down[0], 1);
    check("t2_held_code", 0, held_code[0], 8'h75);
    send('{8'hE0, 8'hF0, 8'h75});
    check("t2_key_down_released", 0, key_down[0], 0);
    check("t2_held_ext", 0, held_ext[0], 1);

    // Typematic repeats with and without filtering
    do_reset();
    base0 = ev_seen[0]; base1 = ev_seen[1];
    send('{8'h15, 8'h15, 8'h15, 8'hF0, 8'h15});
    check("t3_events", 0, ev_seen[0] - base0, 2);
    check("t3_events", 1, ev_seen[1] - base1, 4);
    check("t3_press_count", 0, press_count[0], 1);
    check("t3_press_count", 1, press_count[1], 3);

    // Overflow with a stalled consumer
    do_reset();
    ev_ready = 1'b0;
    send('{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46});
    check("t4_level", 0, fifo_level[0], DEPTH);
    check("t4_overflow", 0, ev_overflow[0], 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tick();
    check("t4_overflow_cleared", 0, ev_overflow[0], 0);
    ev_ready = 1'b1;
    ticks(12);

    // Continuous kb_ready: one pop every other cycle
    kbq.push_back(8'h21); kbq.push_back(8'h22); kbq.push_back(8'h23);
    refresh_kb();
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (!kb_nextdata_n[0]) lows++;
      tick();
    end
    check("t5_pulses", 0, lows, 3);
    check("t5_consumed", 0, kbq.size(), 0);
    ticks(4);

    // Reset after a dangling prefix, then an error byte inside a break
    send('{8'hE0});
    do_reset();
    send('{8'h1C});
    check("t6_make_not_ext", 0, held_ext[0], 0);
    check("t6_key_down", 0, key_down[0], 1);
    send('{8'hF0, 8'hFF, 8'h1C});
    check("t6_ff_discard_keeps_down", 0, key_down[0], 1);
    ticks(4);

    // Randomised traffic with varying back-pressure
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) mode = $urandom_range(0, 3);
      ev_ready = (mode == 0) ? 1'b0 : (mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      clr_ovf  = ($urandom_range(0, 19) == 0);
      if (kbq.size() < 2 && $urandom_range(0, 2) != 0) kbq.push_back(pick_byte());
      if (c == 1500) begin
        clr_ovf = 1'b0;
        do_reset();
      end
      refresh_kb();
      tick();
    end
    clr_ovf = 1'b0;
    ev_ready = 1'b1;
    ticks(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
